// File: rtl/seq_magnitude_comparator_pkg.sv
// rtl/seq_magnitude_comparator_pkg.sv - shared types and parameter checks for the serial comparator
// Purpose: FSM state encoding (ST_IDLE=1'b0, ST_RUN=1'b1) and the WIDTH/STEP legality check
//          used at elaboration time by seq_magnitude_comparator.
// Ports:   none (package).
package seq_magnitude_comparator_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // WIDTH must be at least 2 and an exact multiple of STEP.
    function automatic bit params_ok(input int width, input int step);
        return (width >= 2) && (step >= 1) && ((width % step) == 0);
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_cmp_digit.sv
// rtl/seq_magnitude_comparator_cmp_digit.sv - combinational compare of one STEP-bit digit pair
// Purpose: unsigned magnitude compare of one digit; equality is !dgt && !dlt.
// Ports:   da, db [STEP-1:0] digit of A and B; dgt = da > db; dlt = da < db.
module cmp_digit #(
    parameter int STEP = 2
) (
    input  logic [STEP-1:0] da,
    input  logic [STEP-1:0] db,
    output logic            dgt,
    output logic            dlt
);

    assign dgt = (da > db);
    assign dlt = (da < db);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - digit-serial MSB-first magnitude comparator
// Purpose: compares two WIDTH-bit operands STEP bits per clock under a start/busy/done
//          handshake, signed or unsigned per operation. Optional macro SEQ_CMP_EARLY_EXIT_EN
//          ends the compare at the first unequal digit; without it latency is always NDIG.
// Ports:   clk, rst_n (async, active low); start, signed_mode, a, b (latched on accepted start);
//          busy (compare in progress); done (one-cycle result-valid pulse);
//          agtb / altb / aeqb (held result of the last completed compare).
module seq_magnitude_comparator
    import seq_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             agtb,
    output logic             altb,
    output logic             aeqb
);

    localparam int NDIG = WIDTH / STEP;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]    LAST_DIG  = CW'(NDIG - 1);
    // Flipping the MSB maps two's complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_BIAS = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (!params_ok(WIDTH, STEP)) begin : g_bad_params
            $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of STEP");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             done_q, done_d;
    logic             agtb_q, agtb_d;
    logic             altb_q, altb_d;
    logic             aeqb_q, aeqb_d;

    logic dgt, dlt;
    logic gt_n, lt_n;
    logic finish;

    cmp_digit #(.STEP(STEP)) u_cmp_digit (
        .da  (a_sh_q[WIDTH-1 -: STEP]),
        .db  (b_sh_q[WIDTH-1 -: STEP]),
        .dgt (dgt),
        .dlt (dlt)
    );

    always_comb begin
        // Sticky flags: only the first unequal digit decides the result.
        gt_n = gt_q | (~lt_q & dgt);
        lt_n = lt_q | (~gt_q & dlt);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        finish = (cnt_q == LAST_DIG) || gt_n || lt_n;
`else
        finish = (cnt_q == LAST_DIG);
`endif

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        done_d  = 1'b0;
        agtb_d  = agtb_q;
        altb_d  = altb_q;
        aeqb_d  = aeqb_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = signed_mode ? (a ^ SIGN_BIAS) : a;
                    b_sh_d  = signed_mode ? (b ^ SIGN_BIAS) : b;
                    cnt_d   = '0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q << STEP;
                b_sh_d = b_sh_q << STEP;
                cnt_d  = cnt_q + CW'(1);
                gt_d   = gt_n;
                lt_d   = lt_n;
                if (finish) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    agtb_d  = gt_n;
                    altb_d  = lt_n;
                    aeqb_d  = ~gt_n & ~lt_n;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            done_q  <= 1'b0;
            agtb_q  <= 1'b0;
            altb_q  <= 1'b0;
            aeqb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            done_q  <= done_d;
            agtb_q  <= agtb_d;
            altb_q  <= altb_d;
            aeqb_q  <= aeqb_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign agtb = agtb_q;
    assign altb = altb_q;
    assign aeqb = aeqb_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - self-checking bench for seq_magnitude_comparator
module tb_seq_magnitude_comparator;

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_EQ = 3'b001;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       s8 = 0, sm8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       busy8, done8, gt8, lt8, eq8;

    logic        s16 = 0, sm16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic        busy16, done16, gt16, lt16, eq16;

    logic       s4 = 0, sm4 = 0;
    logic [3:0] a4 = 0, b4 = 0;
    logic       busy4, done4, gt4, lt4, eq4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(8), .STEP(2)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .agtb(gt8), .altb(lt8), .aeqb(eq8));

    seq_magnitude_comparator #(.WIDTH(16), .STEP(4)) u16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .signed_mode(sm16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .agtb(gt16), .altb(lt16), .aeqb(eq16));

    seq_magnitude_comparator #(.WIDTH(4), .STEP(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .signed_mode(sm4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .agtb(gt4), .altb(lt4), .aeqb(eq4));

    // ---------------- reference model (arithmetic compare + latency rule) ----------------
    function automatic logic [2:0] ref_cmp(logic [15:0] a, logic [15:0] b, logic sm, int w);
        int m  = (1 << w) - 1;
        int va = int'(a) & m;
        int vb = int'(b) & m;
        if (sm) begin
            if (va >= (1 << (w - 1))) va = va - (1 << w);
            if (vb >= (1 << (w - 1))) vb = vb - (1 << w);
        end
        if (va > vb) return R_GT;
        if (va < vb) return R_LT;
        return R_EQ;
    endfunction

    function automatic int ref_lat(logic [15:0] a, logic [15:0] b, int w, int step);
        int ndig = w / step;
        int lat  = ndig;
        int d    = (int'(a) ^ int'(b)) & ((1 << w) - 1);
        if (EARLY) begin
            for (int k = ndig - 1; k >= 0; k--)
                if (((d >> (w - step * (k + 1))) & ((1 << step) - 1)) != 0) lat = k + 1;
        end
        return lat;
    endfunction

    bit         m_busy [3];
    bit         m_done [3];
    int         m_left [3];
    logic [2:0] m_res  [3];
    logic [2:0] m_pend [3];

    task automatic model_reset(int i);
        m_busy[i] = 0; m_done[i] = 0; m_left[i] = 0; m_res[i] = 3'b000; m_pend[i] = 3'b000;
    endtask

    task automatic model_edge(int i, logic st, logic sm, logic [15:0] a, logic [15:0] b,
                              int w, int step);
        m_done[i] = 0;
        if (!m_busy[i]) begin
            if (st) begin
                m_busy[i] = 1;
                m_left[i] = ref_lat(a, b, w, step);
                m_pend[i] = ref_cmp(a, b, sm, w);
            end
        end else begin
            m_left[i]--;
            if (m_left[i] == 0) begin
                m_busy[i] = 0;
                m_done[i] = 1;
                m_res[i]  = m_pend[i];
            end
        end
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) model_reset(0); else model_edge(0, s8, sm8, {8'h00, a8}, {8'h00, b8}, 8, 2);
    always @(posedge clk or negedge rst_n)
        if (!rst_n) model_reset(1); else model_edge(1, s16, sm16, a16, b16, 16, 4);
    always @(posedge clk or negedge rst_n)
        if (!rst_n) model_reset(2); else model_edge(2, s4, sm4, {12'h000, a4}, {12'h000, b4}, 4, 4);

    function automatic logic [4:0] obs(int i);
        case (i)
            0:       return {busy8, done8, gt8, lt8, eq8};
            1:       return {busy16, done16, gt16, lt16, eq16};
            2:       return {busy4, done4, gt4, lt4, eq4};
            default: return 5'b0;
        endcase
    endfunction

    // Per-cycle compare of every instance against the model.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            logic [4:0] exp_o;
            exp_o = {m_busy[i], m_done[i], m_res[i]};
            tests++;
            if (obs(i) !== exp_o) begin
                fails++;
                $display("FAIL model_inst%0d busy/done/gt/lt/eq got %b expected %b at %0t",
                         i, obs(i), exp_o, $time);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(string name, int act, int exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic set_in(int i, logic st, logic sm, logic [15:0] a, logic [15:0] b);
        case (i)
            0: begin s8  = st; sm8  = sm; a8  = a[7:0];  b8  = b[7:0];  end
            1: begin s16 = st; sm16 = sm; a16 = a;       b16 = b;       end
            2: begin s4  = st; sm4  = sm; a4  = a[3:0];  b4  = b[3:0];  end
            default: ;
        endcase
    endtask

    function automatic int lat_sel(int fixed_lat, int early_lat);
        return EARLY ? early_lat : fixed_lat;
    endfunction

    // Issue one compare; operands are scrambled right after the start edge.
    task automatic run(int i, string name, logic [15:0] a, logic [15:0] b, logic sm,
                       logic [2:0] eres, int elat);
        int n;
        logic [4:0] o;
        @(negedge clk);
        set_in(i, 1'b1, sm, a, b);
        @(posedge clk); #1;
        set_in(i, 1'b0, ~sm, ~a, ~b);
        n = 0;
        o = obs(i);
        while (!o[3] && n < 40) begin
            @(posedge clk); #1;
            n++;
            o = obs(i);
        end
        chk({name, " latency"}, n, elat);
        chk({name, " result"}, int'(o[2:0]), int'(eres));
        @(negedge clk);
    endtask

    task automatic b2b(int i, string name,
                       logic [15:0] a1, logic [15:0] b1, logic sm1, logic [2:0] r1,
                       logic [15:0] a2, logic [15:0] b2, logic sm2, logic [2:0] r2, int gap);
        int n;
        logic [4:0] o;
        @(negedge clk);
        set_in(i, 1'b1, sm1, a1, b1);
        @(posedge clk); #1;
        set_in(i, 1'b0, 1'b0, 16'h0, 16'h0);
        n = 0;
        o = obs(i);
        while (!o[3] && n < 40) begin @(posedge clk); #1; n++; o = obs(i); end
        chk({name, " first result"}, int'(o[2:0]), int'(r1));
        set_in(i, 1'b1, sm2, a2, b2);
        @(posedge clk); #1;
        set_in(i, 1'b0, 1'b0, 16'h0, 16'h0);
        n = 1;
        o = obs(i);
        chk({name, " first held"}, int'(o[2:0]), int'(r1));
        chk({name, " busy after accept"}, int'(o[4]), 1);
        while (!o[3] && n < 40) begin @(posedge clk); #1; n++; o = obs(i); end
        chk({name, " done gap"}, n, gap);
        chk({name, " second result"}, int'(o[2:0]), int'(r2));
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ndone;
        logic [2:0] got;
        logic [4:0] o;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("reset state", int'(obs(i)), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, "u8 eq 5A/5A",       16'h5A, 16'h5A, 1'b0, R_EQ, 4);
        run(0, "u8 signed 80/7F",   16'h80, 16'h7F, 1'b1, R_LT, lat_sel(4, 1));
        run(0, "u8 unsigned 80/7F", 16'h80, 16'h7F, 1'b0, R_GT, lat_sel(4, 1));
        run(0, "u8 signed FF/00",   16'hFF, 16'h00, 1'b1, R_LT, lat_sel(4, 1));
        run(0, "u8 early C0/40",    16'hC0, 16'h40, 1'b0, R_GT, lat_sel(4, 1));
        run(0, "u8 late 41/40",     16'h41, 16'h40, 1'b0, R_GT, 4);
        run(0, "u8 signed 80/80",   16'h80, 16'h80, 1'b1, R_EQ, 4);
        run(1, "u16 signed 8000/7FFF", 16'h8000, 16'h7FFF, 1'b1, R_LT, lat_sel(4, 1));
        run(2, "u4 signed F/0",     16'hF, 16'h0, 1'b1, R_LT, 1);

        // Start while busy is ignored.
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 16'h10, 16'h20);
        @(posedge clk); #1;
        set_in(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        set_in(0, 1'b1, 1'b0, 16'hFF, 16'h00);
        @(posedge clk); #1;
        set_in(0, 1'b0, 1'b0, 16'h0, 16'h0);
        o = obs(0);
        ndone = o[3] ? 1 : 0;
        got = o[3] ? o[2:0] : 3'b000;
        repeat (10) begin
            @(posedge clk); #1;
            o = obs(0);
            if (o[3]) begin ndone++; got = o[2:0]; end
        end
        chk("busy-start done count", ndone, 1);
        chk("busy-start result", int'(got), int'(R_LT));
        chk("busy-start idle after", int'(o[4]), 0);

        // Asynchronous reset in the middle of a compare.
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 16'h5A, 16'h5A);
        @(posedge clk); #1;
        set_in(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid-op reset outputs", int'(obs(0)), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, "u8 after reset 03/02", 16'h03, 16'h02, 1'b0, R_GT, 4);

        b2b(0, "b2b u8",  16'h20, 16'h10, 1'b0, R_GT, 16'h12, 16'h13, 1'b0, R_LT, 5);
        b2b(1, "b2b u16", 16'h1234, 16'h1234, 1'b0, R_EQ, 16'hABCD, 16'hABCE, 1'b0, R_LT, 5);
        b2b(2, "b2b u4",  16'h5, 16'h3, 1'b0, R_GT, 16'h8, 16'h7, 1'b1, R_LT, 2);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
